// File: rtl/qd_sram_pkg.sv
// Shared encodings for the SRAM arbiter and its cycle sequencer.
package qd_sram_pkg;

  // Sequencer states; numeric values are kept from the legacy encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Which requester owns the access in flight.
  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_CON  = 1'b1
  } gnt_t;

  // Width of the access down-counter and the starvation counter (limits 1..15).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sram_cycle.sv
// SRAM access sequencer: runs one SETUP / ACCESS / HOLD cycle per start and
// generates the active-low strobes and pad output enable.
module sram_cycle
  import qd_sram_pkg::*;
#(
  parameter int unsigned ADDR_W        = 21,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output state_t            o_state,
  output logic              o_capture,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_oe,
  output logic              o_ce_n,
  output logic              o_oe_n,
  output logic              o_we_n
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_dout;
  logic               w_in_access;
  logic               w_last;

  // State sequencing and latching of the access parameters at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (i_start) begin
            r_state <= SETUP;
            r_we    <= i_we;
            r_addr  <= i_addr;
            if (i_we) begin
              r_dout <= i_wdata;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= CNT_W'(ACCESS_CYCLES - 1);
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset releases them at once.
  always_comb begin
    w_in_access = (r_state == ACCESS);
    w_last      = w_in_access && (r_cnt == '0);
    o_state     = r_state;
    o_capture   = w_last && !r_we;
    o_addr      = r_addr;
    o_dout      = r_dout;
    o_ce_n      = (r_state == IDLE);
    o_oe_n      = !(w_in_access && !r_we);
    o_we_n      = !(w_in_access && r_we);
    o_dout_oe   = r_we && (r_state != IDLE);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: host (AVR) and console share one external SRAM.
// Holds arbitration, starvation tracking, grant latch and ack/rdata steering.
module sram_arbiter
  import qd_sram_pkg::*;
#(
  parameter int unsigned ADDR_W        = 21,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_only,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  input  logic              con_req,
  input  logic              con_we,
  input  logic [ADDR_W-1:0] con_addr,
  input  logic [DATA_W-1:0] con_wdata,
  output logic [DATA_W-1:0] con_rdata,
  output logic              con_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_oe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy
);

  state_t            w_state;
  logic              w_capture;
  gnt_t              r_gnt;
  logic [CNT_W-1:0]  r_starve;
  logic [DATA_W-1:0] r_host_rdata;
  logic [DATA_W-1:0] r_con_rdata;
  logic              w_hold;
  logic              w_host_v;
  logic              w_con_v;
  logic              w_pick_con;
  logic              w_start;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Arbitration in IDLE or HOLD; in HOLD the requester being acked is excluded
  // because its req is still high during the ack cycle.
  always_comb begin
    w_hold      = (w_state == HOLD);
    w_host_v    = host_req && !(w_hold && (r_gnt == GNT_HOST));
    w_con_v     = con_req && !host_only && !(w_hold && (r_gnt == GNT_CON));
    w_pick_con  = w_con_v && (!w_host_v || (r_starve != CNT_W'(STARVE_LIMIT)));
    w_start     = ((w_state == IDLE) || w_hold) && (w_host_v || w_con_v);
    w_sel_we    = w_pick_con ? con_we    : host_we;
    w_sel_addr  = w_pick_con ? con_addr  : host_addr;
    w_sel_wdata = w_pick_con ? con_wdata : host_wdata;
  end

  // Starvation counter: console grants while the host waits, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!host_req) begin
      r_starve <= '0;
    end else if (w_start && !w_pick_con) begin
      r_starve <= '0;
    end else if (w_start && (r_starve != CNT_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + CNT_W'(1);
    end
  end

  // Grant latch for ack and read-data steering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt <= GNT_HOST;
    end else if (w_start) begin
      r_gnt <= w_pick_con ? GNT_CON : GNT_HOST;
    end
  end

  // Read data capture on the final ACCESS edge into the granted register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_host_rdata <= '0;
      r_con_rdata  <= '0;
    end else if (w_capture) begin
      if (r_gnt == GNT_CON) begin
        r_con_rdata <= sram_din;
      end else begin
        r_host_rdata <= sram_din;
      end
    end
  end

  sram_cycle #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_cycle (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_we      (w_sel_we),
    .i_addr    (w_sel_addr),
    .i_wdata   (w_sel_wdata),
    .o_state   (w_state),
    .o_capture (w_capture),
    .o_addr    (sram_addr),
    .o_dout    (sram_dout),
    .o_dout_oe (sram_dout_oe),
    .o_ce_n    (sram_ce_n),
    .o_oe_n    (sram_oe_n),
    .o_we_n    (sram_we_n)
  );

  assign host_ack   = w_hold && (r_gnt == GNT_HOST);
  assign con_ack    = w_hold && (r_gnt == GNT_CON);
  assign host_rdata = r_host_rdata;
  assign con_rdata  = r_con_rdata;
  assign busy       = (w_state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 8;
  localparam int unsigned AC = 2;
  localparam int unsigned SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          host_only = 0, host_req = 0, host_we = 0, con_req = 0, con_we = 0;
  logic [AW-1:0] host_addr = '0, con_addr = '0, sram_addr;
  logic [DW-1:0] host_wdata = '0, con_wdata = '0, host_rdata, con_rdata, sram_dout;
  logic [DW-1:0] sram_din = '0;
  logic          host_ack, con_ack, sram_dout_oe, sram_ce_n, sram_oe_n, sram_we_n, busy;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(rst), .host_only(host_only),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .con_req(con_req), .con_we(con_we), .con_addr(con_addr), .con_wdata(con_wdata),
    .con_rdata(con_rdata), .con_ack(con_ack),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_oe(sram_dout_oe), .sram_din(sram_din),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .busy(busy));

  // Second instance built with a single-cycle access strobe.
  logic          host_req1 = 0, host_we1 = 0, con_req1 = 0, con_we1 = 0, host_only1 = 0;
  logic [AW-1:0] host_addr1 = '0, con_addr1 = '0, sram_addr1;
  logic [DW-1:0] host_wdata1 = '0, con_wdata1 = '0, host_rdata1, con_rdata1, sram_dout1;
  logic [DW-1:0] sram_din1 = '0;
  logic          host_ack1, con_ack1, sram_dout_oe1, sram_ce_n1, sram_oe_n1, sram_we_n1, busy1;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1), .STARVE_LIMIT(SL)) dut1 (
    .clk(clk), .reset(rst), .host_only(host_only1),
    .host_req(host_req1), .host_we(host_we1), .host_addr(host_addr1), .host_wdata(host_wdata1),
    .host_rdata(host_rdata1), .host_ack(host_ack1),
    .con_req(con_req1), .con_we(con_we1), .con_addr(con_addr1), .con_wdata(con_wdata1),
    .con_rdata(con_rdata1), .con_ack(con_ack1),
    .sram_addr(sram_addr1), .sram_dout(sram_dout1), .sram_dout_oe(sram_dout_oe1), .sram_din(sram_din1),
    .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1), .sram_we_n(sram_we_n1), .busy(busy1));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // SRAM device on the pins, and the reference memory of the model.
  logic [DW-1:0] smem [int];
  logic [DW-1:0] rmem [int];
  function automatic logic [DW-1:0] srd(input logic [AW-1:0] a);
    return smem.exists(int'(a)) ? smem[int'(a)] : init_val(a);
  endfunction
  function automatic logic [DW-1:0] rrd(input logic [AW-1:0] a);
    return rmem.exists(int'(a)) ? rmem[int'(a)] : init_val(a);
  endfunction

  always @(negedge clk) sram_din <= sram_oe_n ? '0 : srd(sram_addr);
  always @(posedge clk) if (!sram_ce_n && !sram_we_n && sram_dout_oe) smem[int'(sram_addr)] = sram_dout;
  always @(negedge clk) sram_din1 <= sram_oe_n1 ? '0 : (8'hC3 ^ sram_addr1[7:0]);

  // Transaction-level model: one access occupies phases 0 (setup),
  // 1..AC (strobe), AC+1 (ack); arbitration happens when free or acking.
  bit            m_busy = 0, m_who = 0, m_we = 0;
  int            m_phase = 0, m_starve = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_hrd = '0, m_crd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_phase = 0; m_starve = 0; m_hrd = '0; m_crd = '0;
    end else begin
      bit hold, hv, cv, pc, free;
      hold = m_busy && (m_phase == int'(AC) + 1);
      free = !m_busy || hold;
      if (m_busy && m_phase == int'(AC) && !m_we) begin
        if (m_who) m_crd = rrd(m_addr);
        else       m_hrd = rrd(m_addr);
      end
      if (hold && m_we) rmem[int'(m_addr)] = m_wd;
      hv = host_req && !(hold && !m_who);
      cv = con_req && !host_only && !(hold && m_who);
      pc = cv && (!hv || m_starve != int'(SL));
      if (!host_req) m_starve = 0;
      else if (free && (hv || cv)) m_starve = pc ? ((m_starve < int'(SL)) ? m_starve + 1 : int'(SL)) : 0;
      if (free) begin
        if (hv || cv) begin
          m_busy = 1; m_phase = 0; m_who = pc;
          m_we = pc ? con_we : host_we;
          m_addr = pc ? con_addr : host_addr;
          m_wd = pc ? con_wdata : host_wdata;
        end else begin
          m_busy = 0; m_phase = 0;
        end
      end else begin
        m_phase++;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      bit acc;
      acc = m_busy && m_phase >= 1 && m_phase <= int'(AC);
      chk("busy", busy, m_busy);
      chk("ce_n", sram_ce_n, !m_busy);
      chk("oe_n", sram_oe_n, !(acc && !m_we));
      chk("we_n", sram_we_n, !(acc && m_we));
      chk("dout_oe", sram_dout_oe, m_busy && m_we);
      chk("host_ack", host_ack, m_busy && m_phase == int'(AC) + 1 && !m_who);
      chk("con_ack", con_ack, m_busy && m_phase == int'(AC) + 1 && m_who);
      chk("host_rdata", host_rdata, m_hrd);
      chk("con_rdata", con_rdata, m_crd);
      if (m_busy) chk("sram_addr", sram_addr, m_addr);
      if (m_busy && m_we) chk("sram_dout", sram_dout, m_wd);
    end
  end

  task automatic run(input bit hr, input bit hwe, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                     input bit cr, input bit cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                     output int hc, output int cc, output int n0, output int wel, output int oel,
                     output int gap);
    bit hdone, cdone, hdrop, cdrop;
    hc = -1; cc = -1; wel = 0; oel = 0; gap = 0;
    @(posedge clk); #1;
    n0 = cyc;
    if (hr) begin host_req = 1; host_we = hwe; host_addr = ha; host_wdata = hd; end
    if (cr) begin con_req = 1; con_we = cwe; con_addr = ca; con_wdata = cd; end
    hdone = !hr; cdone = !cr; hdrop = 0; cdrop = 0;
    for (int k = 0; k < 60 && !(hdone && cdone); k++) begin
      @(posedge clk); #1;
      if (hdrop) begin host_req = 0; hdone = 1; hdrop = 0; end
      if (cdrop) begin con_req = 0; cdone = 1; cdrop = 0; end
      if (host_ack) begin hc = cyc; hdrop = 1; end
      if (con_ack) begin cc = cyc; cdrop = 1; end
      if (!sram_we_n) wel++;
      if (!sram_oe_n) oel++;
      if (cc >= 0 && hc < 0 && hr && !busy) gap++;
    end
    if (!(hdone && cdone)) begin
      chk("run_timeout", 1, 0);
      host_req = 0; con_req = 0;
    end
  endtask

  logic [AW-1:0] atab [12] = '{21'h00010, 21'h00011, 21'h00012, 21'h00013, 21'h00014, 21'h00015,
                               21'h00016, 21'h00017, 21'h1ABCD, 21'h1FFFFF, 21'h00000, 21'h10000};

  initial begin
    int hc, cc, n0, wel, oel, gap, cnt;
    logic [DW-1:0] rd;
    bit hdp, cdp, cont;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", sram_ce_n, 1); chk("rst_oe_n", sram_oe_n, 1); chk("rst_we_n", sram_we_n, 1);
    chk("rst_dout_oe", sram_dout_oe, 0); chk("rst_addr", sram_addr, 0); chk("rst_dout", sram_dout, 0);
    chk("rst_busy", busy, 0); chk("rst_hrd", host_rdata, 0); chk("rst_crd", con_rdata, 0);
    chk("rst_acks", {host_ack, con_ack}, 0);
    rst = 0;

    // Host write then read back.
    run(1, 1, 21'h1ABCD, 8'h5A, 0, 0, '0, '0, hc, cc, n0, wel, oel, gap);
    chk("wr_ack_lat", hc - n0, 4);
    chk("wr_we_low", wel, 2);
    chk("wr_oe_low", oel, 0);
    run(1, 0, 21'h1ABCD, 8'h00, 0, 0, '0, '0, hc, cc, n0, wel, oel, gap);
    chk("rd_ack_lat", hc - n0, 4);
    chk("rd_oe_low", oel, 2);
    chk("rd_data", host_rdata, 8'h5A);

    // Simultaneous requests: console first, host back-to-back.
    run(1, 1, 21'h00011, 8'hA5, 1, 0, 21'h00010, '0, hc, cc, n0, wel, oel, gap);
    chk("sim_con_lat", cc - n0, 4);
    chk("sim_host_after_con", hc - cc, 4);
    chk("sim_no_idle", gap, 0);

    // host_only blocks the console; release serves it.
    @(posedge clk); #1;
    host_only = 1; con_req = 1; con_we = 0; con_addr = 21'h00012;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (busy || con_ack) cnt++;
    end
    chk("host_only_idle", cnt, 0);
    n0 = cyc; host_only = 0; cc = -1;
    for (int k = 0; k < 20 && cc < 0; k++) begin
      @(posedge clk); #1;
      if (con_ack) cc = cyc;
    end
    chk("host_only_release_lat", cc - n0, 4);
    @(posedge clk); #1 con_req = 0;

    // Reset in the middle of a write access.
    @(posedge clk); #1;
    host_req = 1; host_we = 1; host_addr = 21'h0F0F0; host_wdata = 8'h77;
    cnt = 0;
    while (sram_we_n && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk("mid_wr_reached", sram_we_n, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_ce_n", sram_ce_n, 1); chk("mid_rst_we_n", sram_we_n, 1);
    chk("mid_rst_oe_n", sram_oe_n, 1); chk("mid_rst_dout_oe", sram_dout_oe, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_addr", sram_addr, 0);
    host_req = 0;
    @(posedge clk); #3 rst = 0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (host_ack) cnt++;
    end
    chk("mid_rst_no_ack", cnt, 0);

    // Randomized traffic.
    hdp = 0; cdp = 0; cont = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i % 200 == 0) cont = $urandom_range(1);
      if ($urandom_range(99) == 0) host_only = ~host_only;
      if (hdp) begin
        host_req = 0; hdp = 0;
      end else if (host_ack) begin
        hdp = 1;
      end else if (!host_req && $urandom_range(2) == 0) begin
        host_req = 1; host_we = $urandom_range(1);
        host_addr = atab[$urandom_range(11)]; host_wdata = DW'($urandom);
      end
      if (cdp) begin
        cdp = 0;
        if (cont) begin
          con_we = $urandom_range(1); con_addr = atab[$urandom_range(11)]; con_wdata = DW'($urandom);
        end else begin
          con_req = 0;
        end
      end else if (con_ack) begin
        cdp = 1;
      end else if (!con_req && $urandom_range(2) == 0) begin
        con_req = 1; con_we = $urandom_range(1);
        con_addr = atab[$urandom_range(11)]; con_wdata = DW'($urandom);
      end
    end
    host_only = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (hdp) begin host_req = 0; hdp = 0; end
      else if (host_ack) hdp = 1;
      if (cdp) begin con_req = 0; cdp = 0; end
      else if (con_ack) cdp = 1;
    end
    chk("drain_idle", {busy, host_req, con_req}, 0);

    // Single-cycle strobe build: read at address 0.
    @(posedge clk); #1;
    n0 = cyc; host_req1 = 1; host_we1 = 0; host_addr1 = '0;
    hc = -1; oel = 0; rd = '0;
    for (int k = 0; k < 20 && hc < 0; k++) begin
      @(posedge clk); #1;
      if (!sram_oe_n1) oel++;
      if (host_ack1) begin hc = cyc; rd = host_rdata1; end
    end
    @(posedge clk); #1 host_req1 = 0;
    chk("ac1_ack_lat", hc - n0, 3);
    chk("ac1_oe_low", oel, 1);
    chk("ac1_rdata", rd, 8'hC3);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
